// File: rtl/image_load_if.sv
// Byte-stream / BRAM-write bundle for image_load_ctrl: received UART bytes in, BRAM write port and status out.
interface image_load_if #(
  parameter int unsigned ADDR_W = 19
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_frame_error;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_done;
  logic              err_frame;
  logic              err_timeout;
  logic [1:0]        state;

  modport master (
    output rx_data, rx_valid, rx_frame_error,
    input  wr_en, wr_addr, wr_data, busy, frame_done, err_frame, err_timeout, state
  );

  modport slave (
    input  rx_data, rx_valid, rx_frame_error,
    output wr_en, wr_addr, wr_data, busy, frame_done, err_frame, err_timeout, state
  );
endinterface

// File: rtl/image_load_ctrl.sv
// Loads one image frame from a UART byte stream (SYNC0, SYNC1, then FRAME_PIXELS bytes) into BRAM.
// Define LOAD_TIMEOUT_EN to abort a header/payload when the inter-byte gap reaches TIMEOUT_CYCLES.
module image_load_ctrl #(
  parameter int unsigned FRAME_PIXELS   = 307200,
  parameter int unsigned ADDR_W         = 19,
  parameter logic [7:0]  SYNC0          = 8'hAA,
  parameter logic [7:0]  SYNC1          = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  image_load_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HDR  = 2'b01,
    LOAD = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  if (FRAME_PIXELS < 1 || TIMEOUT_CYCLES < 2 || (64'(FRAME_PIXELS) > (64'd1 << ADDR_W))) begin : g_cfg_check
    $error("image_load_ctrl: FRAME_PIXELS must fit ADDR_W and TIMEOUT_CYCLES must be >= 2");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              err_frame_q, err_frame_d;

  logic clean_byte;
  logic bad_byte;
  logic in_frame;
  logic hdr_accept;
  logic timeout_hit;

  assign clean_byte = bus.rx_valid & ~bus.rx_frame_error;
  assign bad_byte   = bus.rx_valid &  bus.rx_frame_error;
  assign in_frame   = (state_q == HDR) || (state_q == LOAD);
  assign hdr_accept = (state_q == HDR) && clean_byte && (bus.rx_data == SYNC1);

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned    TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_timeout_q, err_timeout_d;

  // Any strobe restarts the gap count, so a byte arriving on the expiry cycle wins.
  assign timeout_hit = in_frame && !bus.rx_valid && (tmr_q == TMR_LAST);

  always_comb begin
    tmr_d         = tmr_q;
    err_timeout_d = err_timeout_q;
    if (!in_frame || bus.rx_valid || timeout_hit) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
    if (timeout_hit) begin
      err_timeout_d = 1'b1;
    end else if (hdr_accept) begin
      err_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.err_timeout = err_timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (clean_byte && (bus.rx_data == SYNC0)) state_d = HDR;
      end
      HDR: begin
        if (bad_byte) begin
          state_d = IDLE;
        end else if (clean_byte) begin
          if (bus.rx_data == SYNC1)      state_d = LOAD;
          else if (bus.rx_data == SYNC0) state_d = HDR;
          else                           state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (bad_byte) begin
          state_d = IDLE;
        end else if (clean_byte) begin
          if (cnt_q == LAST_ADDR) state_d = DONE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write port, pixel counter and framing-error flag
  always_comb begin
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cnt_d       = cnt_q;
    err_frame_d = err_frame_q;
    if (hdr_accept) begin
      cnt_d       = '0;
      err_frame_d = 1'b0;
    end
    if (in_frame && bad_byte) begin
      err_frame_d = 1'b1;
    end
    if ((state_q == LOAD) && clean_byte) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q;
      wr_data_d = bus.rx_data;
      cnt_d     = (cnt_q == LAST_ADDR) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cnt_q       <= '0;
      err_frame_q <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cnt_q       <= cnt_d;
      err_frame_q <= err_frame_d;
    end
  end

  // Output decode
  always_comb begin
    bus.wr_en      = wr_en_q;
    bus.wr_addr    = wr_addr_q;
    bus.wr_data    = wr_data_q;
    bus.err_frame  = err_frame_q;
    bus.state      = state_q;
    bus.busy       = (state_q == HDR) || (state_q == LOAD);
    bus.frame_done = (state_q == DONE);
  end

endmodule

// File: tb/tb_image_load_ctrl.sv
// Bench for image_load_ctrl: directed vector table, hand-written corner sequences and random traffic vs a reference model.
module tb_image_load_ctrl;

  localparam int unsigned FP     = 4;
  localparam int unsigned AW     = 4;
  localparam int unsigned TMO    = 16;
  localparam logic [7:0]  S0     = 8'hAA;
  localparam logic [7:0]  S1     = 8'h55;
`ifdef LOAD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  image_load_if #(.ADDR_W(AW)) bus ();

  image_load_ctrl #(
    .FRAME_PIXELS(FP), .ADDR_W(AW), .SYNC0(S0), .SYNC1(S1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: abstract frame-loader behaviour
  bit       m_wait_s1, m_loading, m_done, m_err_f, m_err_t, m_wr_en;
  int       m_addr, m_gap;
  int       m_wr_addr;
  logic [7:0] m_wr_data;

  task automatic model_update(input logic v, input logic [7:0] d, input logic fe, input logic r);
    bit clean;
    clean   = v && !fe;
    m_wr_en = 1'b0;
    if (r) begin
      m_wait_s1 = 0; m_loading = 0; m_done = 0; m_err_f = 0; m_err_t = 0;
      m_addr = 0; m_gap = 0; m_wr_addr = 0; m_wr_data = 8'h00;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_loading) begin
      if (v && fe) begin
        m_err_f = 1; m_loading = 0;
      end else if (clean) begin
        m_wr_en = 1; m_wr_addr = m_addr; m_wr_data = d; m_gap = 0;
        if (m_addr == FP - 1) begin
          m_addr = 0; m_loading = 0; m_done = 1;
        end else begin
          m_addr++;
        end
      end else begin
        m_gap++;
        if (TMO_EN && m_gap == TMO) begin
          m_loading = 0; m_err_t = 1; m_gap = 0;
        end
      end
    end else if (m_wait_s1) begin
      if (v && fe) begin
        m_err_f = 1; m_wait_s1 = 0;
      end else if (clean) begin
        m_gap = 0;
        if (d == S1) begin
          m_wait_s1 = 0; m_loading = 1; m_addr = 0; m_err_f = 0; m_err_t = 0;
        end else if (d != S0) begin
          m_wait_s1 = 0;
        end
      end else begin
        m_gap++;
        if (TMO_EN && m_gap == TMO) begin
          m_wait_s1 = 0; m_err_t = 1; m_gap = 0;
        end
      end
    end else if (clean && d == S0) begin
      m_wait_s1 = 1; m_gap = 0;
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic fe, input logic r);
    bus.rx_valid       = v;
    bus.rx_data        = d;
    bus.rx_frame_error = fe;
    rst                = r;
    model_update(v, d, fe, r);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model();
    logic [1:0] exp_st;
    exp_st = m_done ? 2'd3 : (m_loading ? 2'd2 : (m_wait_s1 ? 2'd1 : 2'd0));
    check("rnd_state",       32'(bus.state),       32'(exp_st));
    check("rnd_wr_en",       32'(bus.wr_en),       32'(m_wr_en));
    check("rnd_wr_addr",     32'(bus.wr_addr),     32'(m_wr_addr));
    check("rnd_wr_data",     32'(bus.wr_data),     32'(m_wr_data));
    check("rnd_busy",        32'(bus.busy),        32'(m_wait_s1 || m_loading));
    check("rnd_frame_done",  32'(bus.frame_done),  32'(m_done));
    check("rnd_err_frame",   32'(bus.err_frame),   32'(m_err_f));
    check("rnd_err_timeout", 32'(bus.err_timeout), 32'(m_err_t));
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       fe;
    logic       r;
    logic       en;
    logic [3:0] addr;
    logic [7:0] data;
    logic [1:0] st;
    logic       done;
    logic       errf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic fe, input logic r,
                              input logic en, input logic [3:0] addr, input logic [7:0] data,
                              input logic [1:0] st, input logic done, input logic errf);
    vec_t t;
    t.v = v; t.d = d; t.fe = fe; t.r = r; t.en = en; t.addr = addr;
    t.data = data; t.st = st; t.done = done; t.errf = errf;
    return t;
  endfunction

  initial begin
    bit sparse;
    logic v, fe, r;
    logic [7:0] d;
    int sel;

    // Normal frame with one idle gap
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 0, 8'h00, 2, 0, 0));
    tbl.push_back(mk(1, 8'h11, 0, 0, 1, 0, 8'h11, 2, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 1, 1, 8'h22, 2, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h22, 2, 0, 0));
    tbl.push_back(mk(1, 8'h33, 0, 0, 1, 2, 8'h33, 2, 0, 0));
    tbl.push_back(mk(1, 8'h44, 0, 0, 1, 3, 8'h44, 3, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3, 8'h44, 0, 0, 0));
    // Repeated SYNC0, byte during DONE, bad second header byte
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'h44, 1, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'h44, 1, 0, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 3, 8'h44, 2, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 0, 1, 0, 8'h01, 2, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 0, 1, 1, 8'h02, 2, 0, 0));
    tbl.push_back(mk(1, 8'h03, 0, 0, 1, 2, 8'h03, 2, 0, 0));
    tbl.push_back(mk(1, 8'h04, 0, 0, 1, 3, 8'h04, 3, 1, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'h04, 0, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'h04, 1, 0, 0));
    tbl.push_back(mk(1, 8'h12, 0, 0, 0, 3, 8'h04, 0, 0, 0));
    // Framing error in LOAD, ignored in IDLE, cleared by next header
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'h04, 1, 0, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 3, 8'h04, 2, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 0, 1, 0, 8'h01, 2, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 0, 1, 1, 8'h02, 2, 0, 0));
    tbl.push_back(mk(1, 8'h03, 1, 0, 0, 1, 8'h02, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h02, 0, 0, 1));
    tbl.push_back(mk(1, 8'hAA, 1, 0, 0, 1, 8'h02, 0, 0, 1));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 1, 8'h02, 1, 0, 1));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 1, 8'h02, 2, 0, 0));
    tbl.push_back(mk(1, 8'h05, 0, 0, 1, 0, 8'h05, 2, 0, 0));
    tbl.push_back(mk(1, 8'h06, 0, 0, 1, 1, 8'h06, 2, 0, 0));
    tbl.push_back(mk(1, 8'h07, 0, 0, 1, 2, 8'h07, 2, 0, 0));
    tbl.push_back(mk(1, 8'h08, 0, 0, 1, 3, 8'h08, 3, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3, 8'h08, 0, 0, 0));
    // Framing error in HDR
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'h08, 1, 0, 0));
    tbl.push_back(mk(1, 8'h55, 1, 0, 0, 3, 8'h08, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3, 8'h08, 0, 0, 1));
    // Two back-to-back frames
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'h08, 1, 0, 1));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 3, 8'h08, 2, 0, 0));
    tbl.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 8'hA1, 2, 0, 0));
    tbl.push_back(mk(1, 8'hA2, 0, 0, 1, 1, 8'hA2, 2, 0, 0));
    tbl.push_back(mk(1, 8'hA3, 0, 0, 1, 2, 8'hA3, 2, 0, 0));
    tbl.push_back(mk(1, 8'hA4, 0, 0, 1, 3, 8'hA4, 3, 1, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'hA4, 0, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'hA4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 3, 8'hA4, 2, 0, 0));
    tbl.push_back(mk(1, 8'hB1, 0, 0, 1, 0, 8'hB1, 2, 0, 0));
    tbl.push_back(mk(1, 8'hB2, 0, 0, 1, 1, 8'hB2, 2, 0, 0));
    tbl.push_back(mk(1, 8'hB3, 0, 0, 1, 2, 8'hB3, 2, 0, 0));
    tbl.push_back(mk(1, 8'hB4, 0, 0, 1, 3, 8'hB4, 3, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3, 8'hB4, 0, 0, 0));
    // Reset one cycle after third payload strobe, concurrent with a strobe
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 3, 8'hB4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 3, 8'hB4, 2, 0, 0));
    tbl.push_back(mk(1, 8'hC1, 0, 0, 1, 0, 8'hC1, 2, 0, 0));
    tbl.push_back(mk(1, 8'hC2, 0, 0, 1, 1, 8'hC2, 2, 0, 0));
    tbl.push_back(mk(1, 8'hC3, 0, 0, 1, 2, 8'hC3, 2, 0, 0));
    tbl.push_back(mk(1, 8'hC4, 0, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'hC5, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 0, 8'h00, 2, 0, 0));
    tbl.push_back(mk(1, 8'hD0, 0, 0, 1, 0, 8'hD0, 2, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hD0, 2, 0, 0));

    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_frame_error = 1'b0; rst = 1'b1;
    drive_cycle(0, 8'h00, 0, 1);
    drive_cycle(1, 8'hAA, 0, 1);
    check("reset_state",       32'(bus.state),       32'd0);
    check("reset_wr_en",       32'(bus.wr_en),       32'd0);
    check("reset_wr_addr",     32'(bus.wr_addr),     32'd0);
    check("reset_wr_data",     32'(bus.wr_data),     32'd0);
    check("reset_busy",        32'(bus.busy),        32'd0);
    check("reset_frame_done",  32'(bus.frame_done),  32'd0);
    check("reset_err_frame",   32'(bus.err_frame),   32'd0);
    check("reset_err_timeout", 32'(bus.err_timeout), 32'd0);

    foreach (tbl[i]) begin
      drive_cycle(tbl[i].v, tbl[i].d, tbl[i].fe, tbl[i].r);
      check($sformatf("vec%0d_state", i),      32'(bus.state),       32'(tbl[i].st));
      check($sformatf("vec%0d_wr_en", i),      32'(bus.wr_en),       32'(tbl[i].en));
      check($sformatf("vec%0d_wr_addr", i),    32'(bus.wr_addr),     32'(tbl[i].addr));
      check($sformatf("vec%0d_wr_data", i),    32'(bus.wr_data),     32'(tbl[i].data));
      check($sformatf("vec%0d_frame_done", i), 32'(bus.frame_done),  32'(tbl[i].done));
      check($sformatf("vec%0d_busy", i),       32'(bus.busy),        32'(tbl[i].st == 2'd1 || tbl[i].st == 2'd2));
      check($sformatf("vec%0d_err_frame", i),  32'(bus.err_frame),   32'(tbl[i].errf));
      check($sformatf("vec%0d_err_timeout", i),32'(bus.err_timeout), 32'd0);
    end

    // Inter-byte gap handling
    drive_cycle(0, 8'h00, 0, 1);
    drive_cycle(1, 8'hAA, 0, 0);
    drive_cycle(1, 8'h55, 0, 0);
    drive_cycle(1, 8'h01, 0, 0);
`ifdef LOAD_TIMEOUT_EN
    for (int k = 0; k < 15; k++) drive_cycle(0, 8'h00, 0, 0);
    check("gap15_state", 32'(bus.state), 32'd2);
    drive_cycle(1, 8'h02, 0, 0);
    check("gap_edge_byte_wr_en",   32'(bus.wr_en),   32'd1);
    check("gap_edge_byte_wr_addr", 32'(bus.wr_addr), 32'd1);
    check("gap_edge_byte_wr_data", 32'(bus.wr_data), 32'h02);
    check("gap_edge_byte_state",   32'(bus.state),   32'd2);
    for (int k = 0; k < 15; k++) drive_cycle(0, 8'h00, 0, 0);
    check("gap15b_state",       32'(bus.state),       32'd2);
    check("gap15b_err_timeout", 32'(bus.err_timeout), 32'd0);
    drive_cycle(0, 8'h00, 0, 0);
    check("timeout_state",       32'(bus.state),       32'd0);
    check("timeout_err_timeout", 32'(bus.err_timeout), 32'd1);
    check("timeout_busy",        32'(bus.busy),        32'd0);
    drive_cycle(1, 8'hAA, 0, 0);
    check("timeout_sticky", 32'(bus.err_timeout), 32'd1);
    drive_cycle(1, 8'h55, 0, 0);
    check("timeout_cleared", 32'(bus.err_timeout), 32'd0);
`else
    for (int k = 0; k < 40; k++) drive_cycle(0, 8'h00, 0, 0);
    check("long_gap_state",       32'(bus.state),       32'd2);
    check("long_gap_err_timeout", 32'(bus.err_timeout), 32'd0);
    drive_cycle(1, 8'h02, 0, 0);
    check("long_gap_wr_en",   32'(bus.wr_en),   32'd1);
    check("long_gap_wr_addr", 32'(bus.wr_addr), 32'd1);
    check("long_gap_wr_data", 32'(bus.wr_data), 32'h02);
`endif

    // Random traffic against the reference model
    drive_cycle(0, 8'h00, 0, 1);
    sparse = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) sparse = !sparse;
      v   = sparse ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 7);
      d   = (sel < 2) ? S0 : ((sel == 2) ? S1 : 8'($urandom_range(0, 255)));
      fe  = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 299) == 0);
      drive_cycle(v, d, fe, r);
      compare_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_load_ctrl.md
IMAGE_LOAD_CTRL -- requirements
Module: image_load_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FRAME_PIXELS, 307200, bytes per frame (640x480, 8 bpp)
- ADDR_W, 19, BRAM write address width
- SYNC0, 8'hAA, first header byte
- SYNC1, 8'h55, second header byte
- TIMEOUT_CYCLES, 5000000, inter-byte gap limit (100 ms at 50 MHz)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  system clock, 50 MHz; sole clock
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_frame_error  in  1  stop-bit error, qualified by rx_valid
- wr_en  out  1  BRAM write strobe
- wr_addr  out  ADDR_W  BRAM write address
- wr_data  out  8  BRAM write data
- busy  out  1  header or payload in progress
- frame_done  out  1  one-cycle pulse, full frame written
- err_frame  out  1  sticky, load aborted on framing error
- err_timeout  out  1  sticky, load aborted on gap timeout
- state  out  2  current FSM state, debug

Function
REQ-003 FSM states SHALL be IDLE=00, HDR=01, LOAD=10, DONE=11; state output SHALL equal the state register.
REQ-004 IDLE: rx_valid with clean byte equal to SYNC0 -> HDR; any other byte -> stay IDLE, no write.
REQ-005 HDR: clean byte SYNC1 -> LOAD with byte counter 0 and err_frame, err_timeout cleared; SYNC0 -> stay HDR; any other byte -> IDLE.
REQ-006 LOAD: each clean rx_valid SHALL produce wr_en=1 exactly one cycle later, with wr_data = that byte and wr_addr = current counter value; counter then increments.
REQ-007 Header bytes SHALL never be written to BRAM.
REQ-008 wr_en SHALL be 0 on every cycle except one following a clean LOAD byte; wr_addr and wr_data SHALL hold their last values otherwise.
REQ-009 On the byte written at address FRAME_PIXELS-1, next state SHALL be DONE; counter wraps to 0, never exceeds FRAME_PIXELS-1.
REQ-010 DONE SHALL last exactly one cycle with frame_done=1, then -> IDLE; rx_valid during DONE SHALL be ignored.
REQ-011 rx_valid with rx_frame_error=1 in HDR or LOAD SHALL not write, SHALL set err_frame, and SHALL -> IDLE; in IDLE it SHALL be ignored.
REQ-012 busy SHALL be 1 exactly in HDR and LOAD.
REQ-013 Sticky errors SHALL hold until reset or next accepted header (REQ-005).

Reset
REQ-014 rst SHALL be sampled only on clk rising edge and SHALL override every other input, including a concurrent rx_valid.
REQ-015 Under reset: state=IDLE, counter=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, err_frame=0, err_timeout=0, timeout counter=0.
REQ-016 Reset during LOAD SHALL abort the frame, with no write in the reset cycle or the one after.

Configuration
REQ-017 Macro LOAD_TIMEOUT_EN SHALL gate the gap timer.
REQ-018 With LOAD_TIMEOUT_EN: timer clears on entry to HDR and on every rx_valid, counts in HDR/LOAD; reaching TIMEOUT_CYCLES-1 SHALL -> IDLE and set err_timeout; rx_valid in that same cycle SHALL take priority (byte processed, timer cleared).
REQ-019 Without LOAD_TIMEOUT_EN: no timer logic; err_timeout tied 0; HDR/LOAD wait indefinitely.

Verification (FRAME_PIXELS=4, TIMEOUT_CYCLES=16)
REQ-020 AA 55 11 22 33 44 -> writes (0,11)(1,22)(2,33)(3,44), each one cycle after its strobe; frame_done one cycle after last write; state back to 00.
REQ-021 AA AA 55 01 + 3 more bytes -> first write (0,01); AA 12 -> no write, state 00.
REQ-022 AA 55 01 02, then rx_valid with rx_frame_error -> no third write, err_frame=1, state 00; next AA 55 clears err_frame.
REQ-023 (LOAD_TIMEOUT_EN) AA 55 01, then 16 idle cycles -> err_timeout=1, state 00; byte on cycle 15 instead -> load continues.
REQ-024 rst asserted one cycle after third payload strobe -> all outputs 0 next edge, no further writes; new header then restarts at address 0.
REQ-025 Two back-to-back frames -> second frame rewrites addresses 0..3; frame_done pulses twice.
